// File: rtl/accum_var_seq.sv
// Streaming accumulator: reduces up to NUM_TERMS unsigned terms (or fewer, closed by i_last)
// into one widened sum and presents it on a valid/ready handshake, holding it under back-pressure.
module accum_var_seq #(
  parameter  int DATA_WIDTH = 4,
  parameter  int NUM_TERMS  = 4,
  localparam int ACC_WIDTH  = DATA_WIDTH + 1 + $clog2(NUM_TERMS),
  localparam int CNT_WIDTH  = $clog2(NUM_TERMS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic [DATA_WIDTH:0]  i_data_bus,
  input  logic                 i_last,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [ACC_WIDTH-1:0] o_data_bus,
  input  logic                 i_ready,
  output logic [CNT_WIDTH-1:0] o_count
);

  typedef enum logic {ACC, HOLD} state_t;

  state_t               state;
  state_t               next_state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] term;
  logic [ACC_WIDTH-1:0] sum;
  logic                 take;
  logic                 pop;
  logic                 closing;

  // i_last is only ever qualified by take, so X on an idle bus cannot leak in.
  assign term    = ACC_WIDTH'(i_data_bus);
  assign sum     = acc + term;
  assign o_ready = rst & i_en & ((state == ACC) | i_ready);
  assign take    = i_valid & o_ready;
  assign pop     = i_en & o_valid & i_ready;
  assign closing = i_last | (o_count == CNT_WIDTH'(NUM_TERMS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACC;
    else      state <= next_state;
  end

  // A closing take wins over a pop so a same-edge pop/close keeps o_valid high.
  always_comb begin
    next_state = state;
    if (take && closing) next_state = HOLD;
    else if (pop)        next_state = ACC;
  end

  always_comb begin
    o_valid = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      o_data_bus <= '0;
      o_count    <= '0;
    end else if (take) begin
      if (closing) begin
        o_data_bus <= sum;
        acc        <= '0;
        o_count    <= '0;
      end else begin
        acc     <= sum;
        o_count <= o_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_accum_var_seq.sv
// Self-checking bench for accum_var_seq: directed scenarios plus random traffic,
// compared against a group-level model built from a queue of accepted terms.
module tb_accum_var_seq;

  localparam int DATA_WIDTH = 4;
  localparam int NUM_TERMS  = 4;
  localparam int ACC_WIDTH  = DATA_WIDTH + 1 + $clog2(NUM_TERMS);
  localparam int CNT_WIDTH  = $clog2(NUM_TERMS + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 i_en = 1'b0;
  logic                 i_valid = 1'b0;
  logic [DATA_WIDTH:0]  i_data_bus = '0;
  logic                 i_last = 1'b0;
  logic                 o_ready;
  logic                 o_valid;
  logic [ACC_WIDTH-1:0] o_data_bus;
  logic                 i_ready = 1'b0;
  logic [CNT_WIDTH-1:0] o_count;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: terms of the open group, and the presented result.
  int group_q[$];
  int m_valid = 0;
  int m_data  = 0;

  accum_var_seq #(.DATA_WIDTH(DATA_WIDTH), .NUM_TERMS(NUM_TERMS)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid), .i_data_bus(i_data_bus),
    .i_last(i_last), .o_ready(o_ready), .o_valid(o_valid), .o_data_bus(o_data_bus),
    .i_ready(i_ready), .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int group_sum();
    int s = 0;
    foreach (group_q[k]) s += group_q[k];
    return s;
  endfunction

  task automatic check_state(input string tag);
    checkOutput({tag, ".o_valid"}, int'(o_valid), m_valid);
    checkOutput({tag, ".o_data_bus"}, int'(o_data_bus), m_data);
    checkOutput({tag, ".o_count"}, int'(o_count), group_q.size());
  endtask

  // Drives one cycle of inputs, checks o_ready, advances the model at the edge, checks outputs.
  task automatic applyStimulus(input string tag, input logic en, input logic valid,
                               input int data, input logic last, input logic ready);
    int  exp_ready;
    bit  take;
    bit  pop;
    i_en       = en;
    i_valid    = valid;
    i_data_bus = (DATA_WIDTH+1)'(data);
    i_last     = last;
    i_ready    = ready;
    #1;
    exp_ready = (en && (m_valid == 0 || ready)) ? 1 : 0;
    checkOutput({tag, ".o_ready"}, int'(o_ready), exp_ready);
    @(posedge clk);
    if (en) begin
      take = valid && (exp_ready == 1);
      pop  = (m_valid == 1) && ready;
      if (pop) m_valid = 0;
      if (take) begin
        group_q.push_back(data);
        if (last || group_q.size() == NUM_TERMS) begin
          m_data  = group_sum();
          m_valid = 1;
          group_q.delete();
        end
      end
    end
    #1;
    check_state(tag);
  endtask

  // Asserts reset mid-cycle with random inputs, checks the immediate effect, releases it.
  task automatic do_reset();
    i_en       = 1'b1;
    i_valid    = 1'($urandom);
    i_data_bus = (DATA_WIDTH+1)'($urandom);
    i_last     = 1'($urandom);
    i_ready    = 1'($urandom);
    #3;
    rst = 1'b0;
    #1;
    group_q.delete();
    m_valid = 0;
    m_data  = 0;
    check_state("reset");
    checkOutput("reset.o_ready", int'(o_ready), 0);
    @(negedge clk);
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("release.o_ready", int'(o_ready), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    do_reset();

    // Basic group 1..4
    for (int i = 1; i <= 4; i++) applyStimulus("basic", 1, 1, i, 0, 1);
    checkOutput("basic.sum", int'(o_data_bus), 10);
    applyStimulus("basic.pop", 1, 0, 0, 0, 1);

    // Widest terms, then an immediate all-zero group
    for (int i = 0; i < 4; i++) applyStimulus("width", 1, 1, 31, 0, 1);
    checkOutput("width.sum", int'(o_data_bus), 124);
    for (int i = 0; i < 4; i++) applyStimulus("zero", 1, 1, 0, 0, 1);
    checkOutput("zero.sum", int'(o_data_bus), 0);
    applyStimulus("zero.pop", 1, 0, 0, 0, 1);

    // Back-pressure with a stalled term of 9
    for (int i = 0; i < 4; i++) applyStimulus("bp.fill", 1, 1, 5, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("bp.stall", 1, 1, 9, 0, 0);
    checkOutput("bp.held", int'(o_data_bus), 20);
    applyStimulus("bp.release", 1, 1, 9, 0, 1);
    checkOutput("bp.count", int'(o_count), 1);

    // Early close with i_last, then enable freeze mid-group
    do_reset();
    applyStimulus("early", 1, 1, 7, 0, 1);
    applyStimulus("early", 1, 1, 8, 1, 1);
    checkOutput("early.sum", int'(o_data_bus), 15);
    applyStimulus("en.open", 1, 1, 2, 0, 1);
    for (int i = 0; i < 2; i++) applyStimulus("en.off", 0, 1, 6, 1, 1);
    applyStimulus("en.on", 1, 1, 3, 1, 1);
    checkOutput("en.sum", int'(o_data_bus), 5);

    // Same-edge pop and closing first term
    applyStimulus("popclose", 1, 1, 11, 1, 1);
    checkOutput("popclose.sum", int'(o_data_bus), 11);

    // Reset mid-group discards the partial sum
    do_reset();
    applyStimulus("rstmid", 1, 1, 3, 0, 1);
    applyStimulus("rstmid", 1, 1, 3, 0, 1);
    do_reset();
    for (int i = 0; i < 4; i++) applyStimulus("rstmid.after", 1, 1, 1, 0, 1);
    checkOutput("rstmid.sum", int'(o_data_bus), 4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom_range(0, 7) != 0), 1'($urandom),
                    int'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
